// File: rtl/miriscv_mem_arbiter_if.sv
// Bus bundle for miriscv_mem_arbiter: core instruction port, core data port and shared memory port.
// The slave modport is the arbiter's view; master is the core/memory side.
interface miriscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            instr_req_i;
  logic [XLEN-1:0] instr_addr_i;
  logic            instr_rvalid_o;
  logic [XLEN-1:0] instr_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [XLEN/8-1:0] data_be_i;
  logic [XLEN-1:0]   data_addr_i;
  logic [XLEN-1:0]   data_wdata_i;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;

  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Merges core fetch and LSU requests onto one memory port; an in-order ID FIFO routes responses back.
// Define MIRISCV_ARB_RR_EN for round-robin arbitration instead of fixed data-over-instr priority.
module miriscv_mem_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int XLEN        = 32
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  miriscv_mem_arbiter_if.slave bus,
  output logic                 err_o
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

  logic              instr_pend_q;
  logic [XLEN-1:0]   instr_addr_q;
  logic              data_pend_q;
  logic              data_we_q;
  logic [XLEN/8-1:0] data_be_q;
  logic [XLEN-1:0]   data_addr_q;
  logic [XLEN-1:0]   data_wdata_q;

  logic [OUTSTANDING-1:0] fifo_id_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;

  logic lock_q;
  logic lock_sel_q;
  logic free_sel;
  logic sel;
  logic mem_req;
  logic grant;
  logic pop;
  logic orphan;
  logic head_id;

  // Handshake: a transfer happens in a cycle where mem_req_o && mem_gnt_i; while mem_req_o is
  // high and not granted, the presented port and its fields stay frozen (lock_q/lock_sel_q).
`ifdef MIRISCV_ARB_RR_EN
  logic last_q;

  // Pointer moves only on contended grants, so successive ties alternate between the ports.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      last_q <= 1'b0;
    end else if (grant && instr_pend_q && data_pend_q) begin
      last_q <= sel;
    end
  end

  always_comb begin
    free_sel = data_pend_q;
    if (instr_pend_q && data_pend_q) begin
      free_sel = ~last_q;
    end
  end
`else
  assign free_sel = data_pend_q;
`endif

  assign sel     = lock_q ? lock_sel_q : free_sel;
  assign mem_req = (instr_pend_q | data_pend_q) && (count_q != CNT_MAX);
  assign grant   = mem_req && bus.mem_gnt_i;
  assign pop     = bus.mem_rvalid_i && (count_q != '0);
  assign orphan  = bus.mem_rvalid_i && (count_q == '0);
  assign head_id = fifo_id_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      instr_pend_q <= 1'b0;
      instr_addr_q <= '0;
    end else if (bus.instr_req_i && !instr_pend_q) begin
      instr_pend_q <= 1'b1;
      instr_addr_q <= bus.instr_addr_i;
    end else if (grant && !sel) begin
      instr_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      data_pend_q  <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
    end else if (bus.data_req_i && !data_pend_q) begin
      data_pend_q  <= 1'b1;
      data_we_q    <= bus.data_we_i;
      data_be_q    <= bus.data_be_i;
      data_addr_q  <= bus.data_addr_i;
      data_wdata_q <= bus.data_wdata_i;
    end else if (grant && sel) begin
      data_pend_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      lock_q     <= mem_req && !bus.mem_gnt_i;
      lock_sel_q <= sel;
    end
  end

  // A full FIFO never sees a push, since mem_req is gated on the registered count.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      fifo_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (grant) begin
        fifo_id_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (grant && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!grant && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      err_o <= 1'b0;
    end else if ((bus.instr_req_i && instr_pend_q) || (bus.data_req_i && data_pend_q) || orphan) begin
      err_o <= 1'b1;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_req && sel && data_we_q;
  assign bus.mem_be_o    = !mem_req ? '0 : (sel ? data_be_q : '1);
  assign bus.mem_addr_o  = !mem_req ? '0 : (sel ? data_addr_q : instr_addr_q);
  assign bus.mem_wdata_o = (mem_req && sel) ? data_wdata_q : '0;

  assign bus.instr_rvalid_o = pop && !head_id;
  assign bus.data_rvalid_o  = pop && head_id;
  assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: fetch, tie, backpressure, stall, error and reset cases.
// Build with +define+MIRISCV_ARB_RR_EN to check round-robin tie ordering.
module tb_miriscv_mem_arbiter;

  logic clk;
  logic arstn;
  logic err;
  int   n_assert;
  int   n_fail;

  miriscv_mem_arbiter_if #(.XLEN(32)) bus ();

  miriscv_mem_arbiter #(.OUTSTANDING(2), .XLEN(32)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tie(input bit data_first, input string tag);
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h200;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hf; bus.data_addr_i = 32'h8000;
    bus.mem_gnt_i = 1'b1;
    next_cycle();
    bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
    #2;
    chk({tag, "_req1"}, {31'd0, bus.mem_req_o}, 32'd1);
    chk({tag, "_addr1"}, bus.mem_addr_o, data_first ? 32'h8000 : 32'h200);
    next_cycle(); #2;
    chk({tag, "_addr2"}, bus.mem_addr_o, data_first ? 32'h200 : 32'h8000);
    next_cycle();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'ha1;
    #2;
    chk({tag, "_rsp1_data"}, {31'd0, bus.data_rvalid_o}, {31'd0, data_first});
    chk({tag, "_rsp1_instr"}, {31'd0, bus.instr_rvalid_o}, {31'd0, !data_first});
    next_cycle();
    bus.mem_rdata_i = 32'hb2;
    #2;
    chk({tag, "_rsp2_instr"}, {31'd0, bus.instr_rvalid_o}, {31'd0, data_first});
    chk({tag, "_rsp2_rdata"}, data_first ? bus.instr_rdata_o : bus.data_rdata_o, 32'hb2);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    arstn = 1'b0;
    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_i = '0;
    bus.data_addr_i = '0; bus.data_wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset state
    repeat (2) next_cycle();
    arstn = 1'b1;
    #2;
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_irv", {31'd0, bus.instr_rvalid_o}, 32'd0);

    // Single fetch
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h100; bus.mem_gnt_i = 1'b1;
    #2;
    chk("fetch_no_early_req", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.instr_req_i = 1'b0; bus.instr_addr_i = 32'hffff;
    #2;
    chk("fetch_req", {31'd0, bus.mem_req_o}, 32'd1);
    chk("fetch_addr", bus.mem_addr_o, 32'h100);
    chk("fetch_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("fetch_be", {28'd0, bus.mem_be_o}, 32'hf);
    next_cycle(); #2;
    chk("fetch_req_done", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h00000013;
    #2;
    chk("fetch_irv", {31'd0, bus.instr_rvalid_o}, 32'd1);
    chk("fetch_irdata", bus.instr_rdata_o, 32'h13);
    chk("fetch_drv", {31'd0, bus.data_rvalid_o}, 32'd0);
    chk("fetch_drdata", bus.data_rdata_o, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Ties: second tie flips to instr-first only under round-robin
    tie(1'b1, "tie_a");
`ifdef MIRISCV_ARB_RR_EN
    tie(1'b0, "tie_b");
`else
    tie(1'b1, "tie_b");
`endif

    // Backpressure: two outstanding fill the FIFO, third request waits for a pop
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h400;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hf; bus.data_addr_i = 32'h9000;
    bus.mem_gnt_i = 1'b1;
    next_cycle();
    bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
    #2;
    chk("bp_addr1", bus.mem_addr_o, 32'h9000);
    next_cycle(); #2;
    chk("bp_addr2", bus.mem_addr_o, 32'h400);
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h404;
    #2;
    chk("bp_full_a", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.instr_req_i = 1'b0;
    #2;
    chk("bp_full_b", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h11;
    #2;
    chk("bp_pop_drv", {31'd0, bus.data_rvalid_o}, 32'd1);
    chk("bp_pop_same_cycle_req", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b0;
    #2;
    chk("bp_third_req", {31'd0, bus.mem_req_o}, 32'd1);
    chk("bp_third_addr", bus.mem_addr_o, 32'h404);
    next_cycle(); #2;
    chk("bp_full_again", {31'd0, bus.mem_req_o}, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h22;
    #2;
    chk("bp_rsp2_irv", {31'd0, bus.instr_rvalid_o}, 32'd1);
    chk("bp_rsp2_rdata", bus.instr_rdata_o, 32'h22);
    next_cycle();
    bus.mem_rdata_i = 32'h33;
    #2;
    chk("bp_rsp3_irv", {31'd0, bus.instr_rvalid_o}, 32'd1);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Store held for three ungranted cycles
    next_cycle();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'h3;
    bus.data_addr_i = 32'ha000; bus.data_wdata_i = 32'hdeadbeef; bus.mem_gnt_i = 1'b0;
    next_cycle();
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_i = 4'hc;
    bus.data_addr_i = 32'hffff; bus.data_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #2;
      chk("st_addr", bus.mem_addr_o, 32'ha000);
      chk("st_wdata", bus.mem_wdata_o, 32'hdeadbeef);
      chk("st_be", {28'd0, bus.mem_be_o}, 32'h3);
      chk("st_we", {31'd0, bus.mem_we_o}, 32'd1);
    end
    next_cycle();
    bus.mem_gnt_i = 1'b1;
    #2;
    chk("st_grant_addr", bus.mem_addr_o, 32'ha000);
    next_cycle(); #2;
    chk("st_done", {31'd0, bus.mem_req_o}, 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5;
    #1;
    chk("st_drv", {31'd0, bus.data_rvalid_o}, 32'd1);
    chk("st_drdata", bus.data_rdata_o, 32'h5);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Selection locked while instr waits, even after data arrives
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h500; bus.mem_gnt_i = 1'b0;
    next_cycle();
    bus.instr_req_i = 1'b0;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hf; bus.data_addr_i = 32'hb000;
    #2;
    chk("lock_addr_a", bus.mem_addr_o, 32'h500);
    next_cycle();
    bus.data_req_i = 1'b0;
    #2;
    chk("lock_addr_b", bus.mem_addr_o, 32'h500);
    bus.mem_gnt_i = 1'b1;
    next_cycle(); #2;
    chk("lock_addr_next", bus.mem_addr_o, 32'hb000);
    next_cycle(); #2;
    chk("lock_idle", {31'd0, bus.mem_req_o}, 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h66;
    #1;
    chk("lock_rsp1_irv", {31'd0, bus.instr_rvalid_o}, 32'd1);
    next_cycle();
    bus.mem_rdata_i = 32'h77;
    #2;
    chk("lock_rsp2_drv", {31'd0, bus.data_rvalid_o}, 32'd1);
    chk("lock_rsp2_rdata", bus.data_rdata_o, 32'h77);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Duplicate data request while pending
    next_cycle();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_be_i = 4'hf;
    bus.data_addr_i = 32'h600; bus.mem_gnt_i = 1'b0;
    next_cycle();
    bus.data_addr_i = 32'h604;
    #2;
    chk("dup_err_before", {31'd0, err}, 32'd0);
    next_cycle();
    bus.data_req_i = 1'b0;
    #2;
    chk("dup_err", {31'd0, err}, 32'd1);
    chk("dup_addr", bus.mem_addr_o, 32'h600);
    bus.mem_gnt_i = 1'b1;
    next_cycle(); #2;
    chk("dup_dropped", {31'd0, bus.mem_req_o}, 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h88;
    #1;
    chk("dup_rsp", {31'd0, bus.data_rvalid_o}, 32'd1);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset clears sticky error
    next_cycle();
    arstn = 1'b0;
    next_cycle();
    arstn = 1'b1;
    #2;
    chk("rst2_err", {31'd0, err}, 32'd0);
    chk("rst2_req", {31'd0, bus.mem_req_o}, 32'd0);

    // Orphan response with empty FIFO
    next_cycle();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h99;
    #2;
    chk("orph_irv", {31'd0, bus.instr_rvalid_o}, 32'd0);
    chk("orph_drv", {31'd0, bus.data_rvalid_o}, 32'd0);
    chk("orph_drdata", bus.data_rdata_o, 32'd0);
    next_cycle();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #2;
    chk("orph_err", {31'd0, err}, 32'd1);

    // Final reset
    next_cycle();
    arstn = 1'b0;
    next_cycle();
    arstn = 1'b1;
    #2;
    chk("rst3_err", {31'd0, err}, 32'd0);
    chk("rst3_req", {31'd0, bus.mem_req_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
